// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache refill/write-back paths.
// Optional statistics counters are built only when CACHE_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | no owner; arbitrate between i_req and d_req this cycle
// BURST | owner's burst in progress, one beat per mem_ready
module cache_mem_arbiter #(
    parameter int BLOCK_WORDS  = 4,
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_wready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] stat_i_grants,
    output logic [31:0] stat_d_grants,
    output logic [31:0] stat_wait_cycles
);

    localparam int BW = $clog2(BLOCK_WORDS);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BLOCK_WORDS - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    // Clears the word-in-block and byte-in-word bits of a request address.
    localparam logic [31:0] ALIGN_MASK = ~((32'(BLOCK_WORDS) << 2) - 32'd1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state;
    logic          owner_d;
    logic          we;
    logic [31:0]   base;
    logic [BW-1:0] beat;
    logic [SW-1:0] streak;

    logic grant_d;
    logic grant_i;
    logic burst;
    logic beat_done;
    logic last_beat;

    always_comb begin
        burst     = (state == BURST);
        grant_d   = (state == IDLE) && d_req && (!i_req || (streak != STREAK_MAX));
        grant_i   = (state == IDLE) && i_req && !grant_d;
        beat_done = burst && mem_ready;
        last_beat = beat_done && (beat == LAST_BEAT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            we      <= 1'b0;
            base    <= 32'd0;
            beat    <= '0;
            streak  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner_d <= 1'b1;
                        we      <= d_we;
                        base    <= d_addr & ALIGN_MASK;
                        beat    <= '0;
                        state   <= BURST;
                        if (i_req && (streak != STREAK_MAX))
                            streak <= streak + SW'(1);
                    end else if (grant_i) begin
                        owner_d <= 1'b0;
                        we      <= 1'b0;
                        base    <= i_addr & ALIGN_MASK;
                        beat    <= '0;
                        streak  <= '0;
                        state   <= BURST;
                    end
                end
                BURST: begin
                    if (mem_ready) begin
                        beat <= beat + BW'(1);
                        if (beat == LAST_BEAT)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Everything below derives from registered state, so reset clears it at once.
    always_comb begin
        mem_req   = burst;
        mem_we    = burst && we;
        mem_addr  = burst ? (base + (32'(beat) << 2)) : 32'd0;
        mem_wdata = (burst && owner_d && we) ? d_wdata : 32'd0;

        i_rvalid  = beat_done && !owner_d;
        i_rdata   = i_rvalid ? mem_rdata : 32'd0;
        i_done    = last_beat && !owner_d;

        d_rvalid  = beat_done && owner_d && !we;
        d_wready  = beat_done && owner_d && we;
        d_rdata   = d_rvalid ? mem_rdata : 32'd0;
        d_done    = last_beat && owner_d;
    end

`ifdef CACHE_ARB_STATS_EN
    logic i_wait;
    logic d_wait;

    // A requester waits whenever it is asserted but is not the current burst owner.
    always_comb begin
        i_wait = i_req && !(burst && !owner_d);
        d_wait = d_req && !(burst && owner_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_i_grants    <= 32'd0;
            stat_d_grants    <= 32'd0;
            stat_wait_cycles <= 32'd0;
        end else begin
            if (grant_i)
                stat_i_grants <= stat_i_grants + 32'd1;
            if (grant_d)
                stat_d_grants <= stat_d_grants + 32'd1;
            if (i_wait || d_wait)
                stat_wait_cycles <= stat_wait_cycles + 32'd1;
        end
    end
`else
    assign stat_i_grants    = 32'd0;
    assign stat_d_grants    = 32'd0;
    assign stat_wait_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter (BLOCK_WORDS=4, MAX_D_STREAK=2).
// Expected statistics depend on whether CACHE_ARB_STATS_EN is defined for the build.
module tb_cache_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_wready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] stat_i_grants;
    logic [31:0] stat_d_grants;
    logic [31:0] stat_wait_cycles;

    int n_checks = 0;
    int n_errors = 0;

    cache_mem_arbiter #(.BLOCK_WORDS(4), .MAX_D_STREAK(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_req            (i_req),
        .i_addr           (i_addr),
        .i_rvalid         (i_rvalid),
        .i_rdata          (i_rdata),
        .i_done           (i_done),
        .d_req            (d_req),
        .d_we             (d_we),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_wready         (d_wready),
        .d_rvalid         (d_rvalid),
        .d_rdata          (d_rdata),
        .d_done           (d_done),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_ready        (mem_ready),
        .mem_rdata        (mem_rdata),
        .stat_i_grants    (stat_i_grants),
        .stat_d_grants    (stat_d_grants),
        .stat_wait_cycles (stat_wait_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic        exp_owner_d [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        wb_ready    [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] wb_addr     [6] = '{32'h200, 32'h204, 32'h204, 32'h204, 32'h208, 32'h20C};
    logic        wb_done     [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [31:0] exp_ig;
        logic [31:0] exp_dg;
        logic [31:0] exp_wait;
        int          pulses;

        reset = 1'b0; i_req = 1'b0; i_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;

        // Reset state
        #2;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_i_rvalid", 32'(i_rvalid), 32'd0);
        check("rst_d_done", 32'(d_done), 32'd0);
        check("rst_stat_wait", stat_wait_cycles, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("idle_ready_ignored_req", 32'(mem_req), 32'd0);
        check("idle_ready_ignored_rv", 32'(i_rvalid), 32'd0);
        check("idle_ready_ignored_wr", 32'(d_wready), 32'd0);

        // Simultaneous requests: D first, one IDLE cycle, then I
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0300;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_040C;
        #1;
        check("both_latency", 32'(mem_req), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_rdata = 32'hDD00_0000 + 32'(k);
            #1;
            check("both_d_mem_req", 32'(mem_req), 32'd1);
            check("both_d_addr", mem_addr, 32'h400 + 32'(4 * k));
            check("both_d_rvalid", 32'(d_rvalid), 32'd1);
            check("both_d_rdata", d_rdata, 32'hDD00_0000 + 32'(k));
            check("both_i_rvalid", 32'(i_rvalid), 32'd0);
            check("both_d_done", 32'(d_done), (k == 3) ? 32'd1 : 32'd0);
        end
        d_req = 1'b0;
        @(negedge clk);
        #1;
        check("both_gap_idle", 32'(mem_req), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_rdata = 32'h1100_0000 + 32'(k);
            #1;
            check("both_i_addr", mem_addr, 32'h300 + 32'(4 * k));
            check("both_i_rvalid2", 32'(i_rvalid), 32'd1);
            check("both_i_done", 32'(i_done), (k == 3) ? 32'd1 : 32'd0);
            check("both_d_rvalid2", 32'(d_rvalid), 32'd0);
        end
        i_req = 1'b0;
        @(negedge clk);
        #1;
`ifdef CACHE_ARB_STATS_EN
        exp_ig = 32'd1; exp_dg = 32'd1; exp_wait = 32'd6;
`else
        exp_ig = 32'd0; exp_dg = 32'd0; exp_wait = 32'd0;
`endif
        check("stat_i_grants", stat_i_grants, exp_ig);
        check("stat_d_grants", stat_d_grants, exp_dg);
        check("stat_wait_cycles", stat_wait_cycles, exp_wait);

        // I refill from an unaligned address
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0104;
        #1;
        check("irefill_latency", 32'(mem_req), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_rdata = 32'h1111_0000 + 32'(k);
            #1;
            check("irefill_mem_req", 32'(mem_req), 32'd1);
            check("irefill_mem_we", 32'(mem_we), 32'd0);
            check("irefill_addr", mem_addr, 32'h100 + 32'(4 * k));
            check("irefill_rvalid", 32'(i_rvalid), 32'd1);
            check("irefill_rdata", i_rdata, 32'h1111_0000 + 32'(k));
            check("irefill_done", 32'(i_done), (k == 3) ? 32'd1 : 32'd0);
        end
        i_req = 1'b0;
        @(negedge clk);
        #1;
        check("irefill_end_idle", 32'(mem_req), 32'd0);

        // D write-back with mem_ready stalls
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200;
        mem_rdata = 32'hDEAD_BEEF;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            mem_ready = wb_ready[c];
            d_wdata = 32'hD000_0000 + 32'(c);
            #1;
            check("wb_mem_req", 32'(mem_req), 32'd1);
            check("wb_mem_we", 32'(mem_we), 32'd1);
            check("wb_addr", mem_addr, wb_addr[c]);
            check("wb_wdata", mem_wdata, 32'hD000_0000 + 32'(c));
            check("wb_wready", 32'(d_wready), 32'(wb_ready[c]));
            check("wb_rvalid", 32'(d_rvalid), 32'd0);
            check("wb_rdata_zero", d_rdata, 32'd0);
            check("wb_done", 32'(d_done), 32'(wb_done[c]));
            if (d_wready) pulses++;
        end
        d_req = 1'b0; d_we = 1'b0;
        check("wb_pulse_count", 32'(pulses), 32'd4);
        @(negedge clk);
        #1;
        check("wb_end_idle", 32'(mem_req), 32'd0);

        // Asynchronous reset in the middle of a burst
        i_req = 1'b1; i_addr = 32'h0000_0500;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("rstmid_addr", mem_addr, 32'h500 + 32'(4 * k));
        end
        reset = 1'b0;
        #1;
        check("rstmid_mem_req", 32'(mem_req), 32'd0);
        check("rstmid_rvalid", 32'(i_rvalid), 32'd0);
        check("rstmid_done", 32'(i_done), 32'd0);
        check("rstmid_addr0", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstmid_idle", 32'(mem_req), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("regrant_addr", mem_addr, 32'h500 + 32'(4 * k));
            check("regrant_done", 32'(i_done), (k == 3) ? 32'd1 : 32'd0);
        end
        i_req = 1'b0;

        // Anti-starvation: both held, expect D,D,I,D,D,I
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0600;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0700;
        for (int g = 0; g < 6; g++) begin
            if (g != 0) @(negedge clk);
            #1;
            check("streak_gap_idle", 32'(mem_req), 32'd0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                #1;
                check("streak_d_rvalid", 32'(d_rvalid), 32'(exp_owner_d[g]));
                check("streak_i_rvalid", 32'(i_rvalid), 32'(!exp_owner_d[g]));
                if (k == 3) begin
                    check("streak_d_done", 32'(d_done), 32'(exp_owner_d[g]));
                    check("streak_i_done", 32'(i_done), 32'(!exp_owner_d[g]));
                end
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        #1;
        check("final_idle", 32'(mem_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single main-memory port between the instruction-cache refill path and the data-cache refill/write-back path of the pipelined MIPS with caches. Each cache issues block-sized burst requests; the arbiter picks one owner, sequences the burst word by word over the memory handshake and returns data and completion to that owner. Data side has priority, bounded by an anti-starvation streak limit for the instruction side.

## Interface
- BLOCK_WORDS, 4, words per burst; power of two, ≥2
- MAX_D_STREAK, 4, consecutive D grants allowed while I waits; ≥1
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  I-cache refill request; held until i_done
- i_addr  in  32  I-cache byte address; block-aligned internally
- i_rvalid  out  1  read word valid this cycle
- i_rdata  out  32  read word
- i_done  out  1  last beat of I burst completes this cycle
- d_req  in  1  D-cache request; held until d_done
- d_we  in  1  1 = write-back burst, 0 = refill; sampled at grant
- d_addr  in  32  D-cache byte address; block-aligned internally
- d_wdata  in  32  write word for current beat
- d_wready  out  1  current write word accepted this cycle
- d_rvalid  out  1  read word valid this cycle
- d_rdata  out  32  read word
- d_done  out  1  last beat of D burst completes this cycle
- mem_req  out  1  memory beat request
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory word byte address
- mem_wdata  out  32  memory write data
- mem_ready  in  1  beat completes this cycle
- mem_rdata  in  32  read data, valid with mem_ready
- stat_i_grants, stat_d_grants, stat_wait_cycles  out  32 each  statistics (see Configuration)

## Operation
- States: IDLE, BURST. Registers: owner (I/D), we, base address, beat counter (log2(BLOCK_WORDS) bits), streak counter.
- IDLE arbitration (combinational, registered at edge):
  - only d_req → grant D; only i_req → grant I; neither → stay IDLE.
  - both: grant D unless streak == MAX_D_STREAK, then grant I.
  - streak: +1 on D grant while i_req high; cleared on any I grant; unchanged on D grant with i_req low; saturates at MAX_D_STREAK.
- Grant: capture base = addr with bits [log2(BLOCK_WORDS)+1:0] cleared; we = d_we for D, 0 for I; beat = 0; go BURST.
- BURST: mem_req = 1, mem_we = we, mem_addr = base + 4·beat, mem_wdata = d_wdata (D write) else 0.
  - mem_ready high: beat completes; beat increments; owner's rvalid (read) or d_wready (write) high same cycle; rdata = mem_rdata.
  - last beat (beat == BLOCK_WORDS−1 with mem_ready): owner's done high same cycle; next state IDLE.
- Non-owner rvalid/wready/done always 0. rdata outputs driven 0 when rvalid low.
- Requester dropping req mid-burst is ignored; burst runs to completion.
- Requester must deassert req in the cycle after done; req still high in IDLE is a new request.

## Timing
- Reset (asynchronous): state IDLE, streak 0, beat 0, all outputs 0 immediately, including mid-burst (mem_req drops, burst abandoned, no done).
- Grant latency: req high in IDLE at edge N → mem_req high from N+1.
- Burst length = BLOCK_WORDS cycles with mem_ready high; any mem_ready-low cycle stretches it, outputs held stable.
- One IDLE cycle between consecutive bursts; minimum back-to-back period BLOCK_WORDS+1 cycles.
- mem_ready while mem_req low: ignored.

## Configuration
- CACHE_ARB_STATS_EN defined: stat_i_grants/stat_d_grants increment per grant; stat_wait_cycles increments each cycle a requester is high and not owner (both waiting counts 1). Wrap modulo 2^32; cleared by reset.
- Undefined: counters not built; stat outputs tied 0.

## Test plan
- I refill, i_addr 0x0000_0104, mem_ready always 1 → mem_addr 0x100,0x104,0x108,0x10C on cycles 1–4, i_rvalid 4 cycles, i_done on 4th, mem_we 0.
- i_req and d_req (d_we=0) raised same cycle → D burst first, d_done, one IDLE cycle, then I burst.
- MAX_D_STREAK=2, d_req continuously re-asserted, i_req held → grants D,D,I,D,D,I; streak resets after I.
- D write-back, d_addr 0x200, mem_ready pattern 1,0,0,1,1,1 → mem_addr holds 0x204 during stalls, d_wready exactly 4 pulses, mem_we 1, d_done on final pulse.
- Reset low during beat 2 → mem_req 0 without clock edge, no done; after release, pending i_req regranted from beat 0.
- With CACHE_ARB_STATS_EN: scenario 2 → stat_d_grants 1, stat_i_grants 1, stat_wait_cycles 6 (BLOCK_WORDS=4); without macro all stats 0.
